spi_stream_adapter: RTL and testbench
=====================================

# spi_stream_adapter

Downstream protocol stage for the SPI minion. It decodes each completed minion frame (`push_en`/`push_msg`) into a val/rdy write stream toward the design, and buffers design responses for the next outgoing frame (`pull_en`/`pull_msg`). Each direction has its own FIFO. Flow-control bits carried inside the frame let the SPI master avoid overflow and underflow.

## Interface
Parameters:
- `nbits`, 10, minion frame width; payload width is `nbits-2`; minimum 3
- `num_entries`, 1, depth of each FIFO; minimum 1

Ports:
- `clk`  input  1  clock
- `reset`  input  1  asynchronous, active-low reset (asserted at 0)
- `push_en`  input  1  minion frame received (one-cycle pulse at end of transaction)
- `push_msg`  input  nbits  received frame: [nbits-1] `val_wrt`, [nbits-2] `val_rd`, [nbits-3:0] data
- `pull_en`  input  1  minion loads outgoing frame this cycle (pulse at start of transaction)
- `pull_msg`  output  nbits  outgoing frame: [nbits-1] `spc`, [nbits-2] `val`, [nbits-3:0] read-FIFO head
- `send_val`  output  1  write-FIFO head valid
- `send_rdy`  input  1  design accepts head
- `send_msg`  output  nbits-2  write-FIFO head
- `recv_val`  input  1  design offers response
- `recv_rdy`  output  1  read FIFO not full
- `recv_msg`  input  nbits-2  response data

## Operation
- **Write FIFO (SPI to design)**
  - On `push_en` with `val_wrt`=1, enqueue `push_msg[nbits-3:0]` when the FIFO is not full.
  - When the FIFO is full, drop the data with no other state change.
  - `send_val` = not empty. `send_msg` = head. Dequeue on `send_val & send_rdy`.
- **Read FIFO (design to SPI)**
  - `recv_rdy` = not full. Enqueue on `recv_val & recv_rdy`.
- **Outgoing frame**
  - `pull_msg` is combinational from registered state.
  - `spc` = write FIFO not full.
  - `val` = read FIFO not empty.
  - Data field = read-FIFO head, or 0 when empty.
- **Read commit**
  - On `pull_en`, register `rd_pend` <= read FIFO not empty.
  - On `push_en` with `val_rd`=1 and `rd_pend`=1, dequeue the read-FIFO head and clear `rd_pend`.
  - `val_rd`=1 with `rd_pend`=0 is ignored.
- **FIFO occupancy**
  - Each FIFO uses a circular buffer with pointers that wrap at `num_entries`.
  - The count is `$clog2(num_entries+1)` bits wide.
  - Enqueue and dequeue in the same cycle are both honoured; the count stays unchanged.
- **Simultaneous `push_en` and `pull_en`**
  - The push is processed on that edge.
  - `pull_msg` and `rd_pend` both reflect the pre-push state.
- **Stability guarantee**
  - The head data of the read FIFO cannot change between `pull_en` and its committing `push_en`, because the only dequeue path is a commit.
  - Write-FIFO space only grows between `pull_en` and `push_en`.
  - Therefore a master that honours `spc` never loses data.

## Timing
- **Reset state**
  - Both FIFOs empty, `rd_pend`=0.
  - `send_val`=0, `send_msg`=0, `recv_rdy`=1.
  - `pull_msg` = {1, 0, 0...0}.
- Reset assertion mid-transaction discards both FIFOs and any pending commit immediately, without waiting for a clock.
- **Write latency:** data pushed at edge N appears on `send_msg` with `send_val`=1 after edge N (visible in cycle N+1).
- **Read latency:** data accepted on `recv` at edge N is reflected in `pull_msg` (`val`=1) in cycle N+1.
- `recv_rdy` and `send_val` depend only on registered state, with no combinational path from `send_rdy`/`recv_val`.
- No bypass: a full FIFO stays not-ready in a cycle where it is also dequeuing.

## Configuration
- **`SPI_ADAPTER_OVF_EN` defined**
  - Adds output `overflow` (1 bit).
  - `overflow` is sticky: set on the edge that drops a write because the write FIFO is full.
  - It is also set on a `val_rd`=1 push with `rd_pend`=0 (read underflow).
  - Cleared only by reset; reset value 0.
- **`SPI_ADAPTER_OVF_EN` undefined**
  - No `overflow` port or logic.
  - Drops and ignored reads are silent.

## Test plan
With `nbits`=10, `num_entries`=2:
1. Reset release, then `push_en` with `push_msg`=10'b10_1010_0101 → next cycle `send_val`=1, `send_msg`=8'hA5; with `send_rdy`=1 it clears after one edge.
2. Three write frames 8'h01, 8'h02, 8'h03 with `send_rdy`=0 → `spc`=0 after the second; 8'h03 dropped (`overflow`=1 when enabled); drain yields 8'h01 then 8'h02.
3. `recv` 8'h3C, then `pull_en` → `pull_msg`=10'b11_0011_1100; `push_en` with `val_rd`=1 → read FIFO empty; next `pull_msg`=10'b10_0000_0000.
4. `pull_en` with read FIFO empty, then `recv` 8'h77, then `push_en` with `val_rd`=1 → no dequeue (`overflow`=1 when enabled); next `pull_msg` val=1, data 8'h77.
5. `recv` and `send` handshakes coincident with `push_en` on a FIFO holding one entry → count unchanged; order preserved across a wrap of 5 entries.
6. Reset asserted between `pull_en` and `push_en` with both FIFOs holding data → all outputs return immediately to their reset values; the later `push_en` with `val_rd`=1 dequeues nothing.

Source files
------------

// File: rtl/spi_stream_adapter.sv
// Protocol stage behind the SPI minion: decodes received frames into a val/rdy write stream and
// buffers design responses for the next outgoing frame. Define SPI_ADAPTER_OVF_EN for `overflow`.
module spi_stream_adapter #(
   parameter int unsigned nbits       = 10,
   parameter int unsigned num_entries = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_en,
   input  logic [nbits-1:0] push_msg,
   input  logic             pull_en,
   output logic [nbits-1:0] pull_msg,
   output logic             send_val,
   input  logic             send_rdy,
   output logic [nbits-3:0] send_msg,
   input  logic             recv_val,
   output logic             recv_rdy,
   input  logic [nbits-3:0] recv_msg
`ifdef SPI_ADAPTER_OVF_EN
   ,
   output logic             overflow
`endif
);

   localparam int unsigned PtrW  = (num_entries > 1) ? $clog2(num_entries) : 1;
   localparam int unsigned CntW  = $clog2(num_entries + 1);
   localparam int unsigned DataW = nbits - 2;

   localparam logic [PtrW-1:0] LastPtr = PtrW'(num_entries - 1);
   localparam logic [CntW-1:0] FullCnt = CntW'(num_entries);

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == LastPtr) ? '0 : p + 1'b1;
   endfunction

   // Frame fields
   logic             val_wrt;
   logic             val_rd;
   logic [DataW-1:0] push_data;

   assign val_wrt   = push_msg[nbits-1];
   assign val_rd    = push_msg[nbits-2];
   assign push_data = push_msg[DataW-1:0];

   // Write FIFO (SPI to design)
   logic [DataW-1:0] wr_mem_q [num_entries];
   logic [PtrW-1:0]  wr_wptr_q;
   logic [PtrW-1:0]  wr_rptr_q;
   logic [CntW-1:0]  wr_cnt_q;
   logic             wr_full;
   logic             wr_empty;
   logic             wr_enq;
   logic             wr_deq;

   assign wr_full  = (wr_cnt_q == FullCnt);
   assign wr_empty = (wr_cnt_q == '0);
   assign wr_enq   = push_en & val_wrt & ~wr_full;
   assign wr_deq   = send_val & send_rdy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(num_entries); i++) wr_mem_q[i] <= '0;
         wr_wptr_q <= '0;
         wr_rptr_q <= '0;
         wr_cnt_q  <= '0;
      end else begin
         if (wr_enq) begin
            wr_mem_q[wr_wptr_q] <= push_data;
            wr_wptr_q           <= next_ptr(wr_wptr_q);
         end
         if (wr_deq) wr_rptr_q <= next_ptr(wr_rptr_q);
         case ({wr_enq, wr_deq})
            2'b10:   wr_cnt_q <= wr_cnt_q + 1'b1;
            2'b01:   wr_cnt_q <= wr_cnt_q - 1'b1;
            default: wr_cnt_q <= wr_cnt_q;
         endcase
      end
   end

   assign send_val = ~wr_empty;
   assign send_msg = wr_empty ? '0 : wr_mem_q[wr_rptr_q];

   // Read FIFO (design to SPI)
   logic [DataW-1:0] rd_mem_q [num_entries];
   logic [PtrW-1:0]  rd_wptr_q;
   logic [PtrW-1:0]  rd_rptr_q;
   logic [CntW-1:0]  rd_cnt_q;
   logic             rd_full;
   logic             rd_empty;
   logic             rd_enq;
   logic             rd_deq;
   logic             rd_pend_q;

   assign rd_full  = (rd_cnt_q == FullCnt);
   assign rd_empty = (rd_cnt_q == '0);
   assign rd_enq   = recv_val & recv_rdy;
   // A commit is the only way the read head leaves, so it is stable while a frame is in flight
   assign rd_deq   = push_en & val_rd & rd_pend_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(num_entries); i++) rd_mem_q[i] <= '0;
         rd_wptr_q <= '0;
         rd_rptr_q <= '0;
         rd_cnt_q  <= '0;
      end else begin
         if (rd_enq) begin
            rd_mem_q[rd_wptr_q] <= recv_msg;
            rd_wptr_q           <= next_ptr(rd_wptr_q);
         end
         if (rd_deq) rd_rptr_q <= next_ptr(rd_rptr_q);
         case ({rd_enq, rd_deq})
            2'b10:   rd_cnt_q <= rd_cnt_q + 1'b1;
            2'b01:   rd_cnt_q <= rd_cnt_q - 1'b1;
            default: rd_cnt_q <= rd_cnt_q;
         endcase
      end
   end

   // A new frame load samples the pre-push FIFO state and wins over a same-edge commit clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend_q <= 1'b0;
      end else if (pull_en) begin
         rd_pend_q <= ~rd_empty;
      end else if (rd_deq) begin
         rd_pend_q <= 1'b0;
      end
   end

   assign recv_rdy = ~rd_full;
   assign pull_msg = {~wr_full, ~rd_empty, (rd_empty ? {DataW{1'b0}} : rd_mem_q[rd_rptr_q])};

`ifdef SPI_ADAPTER_OVF_EN
   logic overflow_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_q <= 1'b0;
      end else if (push_en && ((val_wrt && wr_full) || (val_rd && !rd_pend_q))) begin
         overflow_q <= 1'b1;
      end
   end

   assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_spi_stream_adapter.sv
// Self-checking bench for spi_stream_adapter (nbits=10, num_entries=2) using queue scoreboards.
module tb_spi_stream_adapter;

   localparam int unsigned nbits       = 10;
   localparam int unsigned num_entries = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       push_en, pull_en, send_val, send_rdy, recv_val, recv_rdy;
   logic [9:0] push_msg, pull_msg;
   logic [7:0] send_msg, recv_msg;
`ifdef SPI_ADAPTER_OVF_EN
   logic       overflow;
`endif

   int checks = 0;
   int errors = 0;
   logic [7:0] wq[$];
   logic [7:0] rq[$];

   spi_stream_adapter #(
      .nbits       (nbits),
      .num_entries (num_entries)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .push_en  (push_en),
      .push_msg (push_msg),
      .pull_en  (pull_en),
      .pull_msg (pull_msg),
      .send_val (send_val),
      .send_rdy (send_rdy),
      .send_msg (send_msg),
      .recv_val (recv_val),
      .recv_rdy (recv_rdy),
      .recv_msg (recv_msg)
`ifdef SPI_ADAPTER_OVF_EN
      ,
      .overflow (overflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      push_en = 1'b0; push_msg = '0; pull_en = 1'b0;
      send_rdy = 1'b0; recv_val = 1'b0; recv_msg = '0;
   endtask

   task automatic push_frame(input logic vw, input logic vr, input logic [7:0] d);
      push_en = 1'b1; push_msg = {vw, vr, d};
      step();
      push_en = 1'b0; push_msg = '0;
   endtask

   task automatic recv_word(input logic [7:0] d);
      recv_val = 1'b1; recv_msg = d;
      step();
      recv_val = 1'b0; recv_msg = '0;
   endtask

   task automatic pull_pulse();
      pull_en = 1'b1;
      step();
      pull_en = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      #2 reset = 1'b0;
      #10;
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL reset_send_val got %b want 0", send_val); end
      checks++; if (send_msg !== 8'h00) begin errors++; $display("FAIL reset_send_msg got %h want 00", send_msg); end
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL reset_recv_rdy got %b want 1", recv_rdy); end
      checks++; if (pull_msg !== 10'h200) begin errors++; $display("FAIL reset_pull_msg got %h want 200", pull_msg); end
      @(negedge clk);
      reset = 1'b1;
      step();
      checks++; if (pull_msg !== 10'h200) begin errors++; $display("FAIL release_pull_msg got %h want 200", pull_msg); end
`ifdef SPI_ADAPTER_OVF_EN
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
   endtask

   task automatic test_write();
      logic [7:0] exp;
      wq.push_back(8'hA5);
      push_frame(1'b1, 1'b0, 8'hA5);
      exp = wq.pop_front();
      checks++; if (send_val !== 1'b1) begin errors++; $display("FAIL write_send_val got %b want 1", send_val); end
      checks++; if (send_msg !== exp) begin errors++; $display("FAIL write_send_msg got %h want %h", send_msg, exp); end
      send_rdy = 1'b1;
      step();
      send_rdy = 1'b0;
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL write_drained got %b want 0", send_val); end
   endtask

   task automatic test_write_full();
      logic [7:0] exp;
      for (int i = 1; i <= 3; i++) begin
         if (wq.size() < num_entries) wq.push_back(8'(i));
         push_frame(1'b1, 1'b0, 8'(i));
         checks++;
         if (pull_msg[9] !== (wq.size() < num_entries)) begin
            errors++;
            $display("FAIL full_spc_%0d got %b want %b", i, pull_msg[9], wq.size() < num_entries);
         end
      end
`ifdef SPI_ADAPTER_OVF_EN
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL full_overflow got %b want 1", overflow); end
`endif
      send_rdy = 1'b1;
      for (int n = 0; n < 4 && wq.size() > 0; n++) begin
         exp = wq.pop_front();
         checks++;
         if (send_val !== 1'b1 || send_msg !== exp) begin
            errors++;
            $display("FAIL full_drain got val %b msg %h want val 1 msg %h", send_val, send_msg, exp);
         end
         step();
      end
      send_rdy = 1'b0;
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL full_drop got send_val %b want 0", send_val); end
      checks++; if (pull_msg[9] !== 1'b1) begin errors++; $display("FAIL full_spc_after got %b want 1", pull_msg[9]); end
   endtask

   task automatic test_read_commit();
      rq.push_back(8'h3C);
      recv_word(8'h3C);
      pull_pulse();
      checks++; if (pull_msg !== 10'h33C) begin errors++; $display("FAIL commit_pull_msg got %h want 33c", pull_msg); end
      push_frame(1'b0, 1'b1, 8'h00);
      void'(rq.pop_front());
      checks++; if (pull_msg !== 10'h200) begin errors++; $display("FAIL commit_after got %h want 200", pull_msg); end
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL commit_recv_rdy got %b want 1", recv_rdy); end
   endtask

   task automatic test_read_underflow();
      pull_pulse();
      rq.push_back(8'h77);
      recv_word(8'h77);
      push_frame(1'b0, 1'b1, 8'h00);
      checks++;
      if (pull_msg !== {2'b11, rq[0]}) begin
         errors++; $display("FAIL underflow_pull_msg got %h want %h", pull_msg, {2'b11, rq[0]});
      end
`ifdef SPI_ADAPTER_OVF_EN
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL underflow_overflow got %b want 1", overflow); end
`endif
      pull_pulse();
      push_frame(1'b0, 1'b1, 8'h00);
      void'(rq.pop_front());
      checks++; if (pull_msg !== 10'h200) begin errors++; $display("FAIL underflow_cleanup got %h want 200", pull_msg); end
   endtask

   task automatic test_back_to_back();
      wq.push_back(8'h10);
      push_frame(1'b1, 1'b0, 8'h10);
      rq.push_back(8'h50);
      recv_word(8'h50);
      pull_pulse();
      for (int i = 0; i < 5; i++) begin
         logic [7:0] wd;
         logic [7:0] rd;
         wd = 8'h11 + 8'(i);
         rd = 8'h51 + 8'(i);
         push_en = 1'b1; push_msg = {2'b11, wd}; pull_en = 1'b1;
         send_rdy = 1'b1; recv_val = 1'b1; recv_msg = rd;
         checks++;
         if (send_val !== 1'b1 || send_msg !== wq[0]) begin
            errors++; $display("FAIL b2b_send_%0d got val %b msg %h want val 1 msg %h", i, send_val, send_msg, wq[0]);
         end
         checks++;
         if (pull_msg !== {2'b11, rq[0]}) begin
            errors++; $display("FAIL b2b_pull_%0d got %h want %h", i, pull_msg, {2'b11, rq[0]});
         end
         checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL b2b_recv_rdy_%0d got %b want 1", i, recv_rdy); end
         void'(wq.pop_front()); wq.push_back(wd);
         void'(rq.pop_front()); rq.push_back(rd);
         step();
      end
      idle_inputs();
      checks++;
      if (send_val !== 1'b1 || send_msg !== wq[0]) begin
         errors++; $display("FAIL b2b_send_end got val %b msg %h want val 1 msg %h", send_val, send_msg, wq[0]);
      end
      checks++;
      if (pull_msg !== {2'b11, rq[0]}) begin
         errors++; $display("FAIL b2b_pull_end got %h want %h", pull_msg, {2'b11, rq[0]});
      end
   endtask

   task automatic test_reset_midframe();
      pull_pulse();
      #2 reset = 1'b0;
      #1;
      checks++; if (send_val !== 1'b0) begin errors++; $display("FAIL midrst_send_val got %b want 0", send_val); end
      checks++; if (send_msg !== 8'h00) begin errors++; $display("FAIL midrst_send_msg got %h want 00", send_msg); end
      checks++; if (recv_rdy !== 1'b1) begin errors++; $display("FAIL midrst_recv_rdy got %b want 1", recv_rdy); end
      checks++; if (pull_msg !== 10'h200) begin errors++; $display("FAIL midrst_pull_msg got %h want 200", pull_msg); end
`ifdef SPI_ADAPTER_OVF_EN
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_overflow got %b want 0", overflow); end
`endif
      wq.delete();
      rq.delete();
      #1 reset = 1'b1;
      push_frame(1'b0, 1'b1, 8'h00);
      checks++; if (pull_msg !== 10'h200) begin errors++; $display("FAIL midrst_push got %h want 200", pull_msg); end
      rq.push_back(8'h22);
      recv_word(8'h22);
      push_frame(1'b0, 1'b1, 8'h00);
      checks++;
      if (pull_msg !== {2'b11, rq[0]}) begin
         errors++; $display("FAIL midrst_pend_cleared got %h want %h", pull_msg, {2'b11, rq[0]});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write();
      test_write_full();
      test_read_commit();
      test_read_underflow();
      test_back_to_back();
      test_reset_midframe();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
